// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VERIFY,
        ST_RUN,
        ST_ERROR
    } state_e;

    localparam int WORD_BYTES = 4;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);

    localparam state_e      RST_STATE = ST_IDLE;
    localparam logic [31:0] RST_ADDR  = 32'h0000_0000;
    localparam logic        RST_FLAG  = 1'b0;

    function automatic logic [31:0] word_to_byte(input logic [31:0] idx);
        return idx << WORD_SHIFT;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Instruction stream handshake plus the CPU external instruction-memory port.
interface imem_loader_if #(
    parameter int DATA_W = 32
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic [31:0]       addr_ext;
    logic              wen_ext;
    logic              ren_ext;
    logic [DATA_W-1:0] wdata_ext;
    logic [DATA_W-1:0] rdata_ext;

    modport master (
        input  s_valid, s_data, rdata_ext,
        output s_ready, addr_ext, wen_ext, ren_ext, wdata_ext
    );

    modport slave (
        output s_valid, s_data, rdata_ext,
        input  s_ready, addr_ext, wen_ext, ren_ext, wdata_ext
    );
endinterface

// File: rtl/imem_checksum.sv
// 32-bit wrapping accumulator with synchronous clear; clear wins over accumulate.
module imem_checksum (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] din,
    output logic [31:0] sum
);
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + din;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Streams instruction words into IMEM, then enables the CPU.
// Define IMEM_LOADER_VERIFY_EN to add the read-back checksum pass before RUN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            start,
    input  logic [ADDR_W:0] len,
    input  logic [31:0]     checksum,
    imem_loader_if.master   bus,
    output logic            cpu_enable,
    output logic            busy,
    output logic            error
);
    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_e            state;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   len_q;
    logic [31:0]       addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic              s_ready;
    logic              accept;
    logic              session_start;
    logic              len_legal;

    assign s_ready       = (state == ST_LOAD) && (cnt < len_q);
    assign accept        = bus.s_valid && s_ready;
    assign session_start = start && (state inside {ST_IDLE, ST_RUN, ST_ERROR});
    assign len_legal     = (len != '0) && (len <= CAPACITY);

    assign bus.s_ready   = s_ready;
    assign bus.addr_ext  = addr_q;
    assign bus.wen_ext   = wen_q;
    assign bus.wdata_ext = wdata_q;

`ifdef IMEM_LOADER_VERIFY_EN
    logic        ren_q;
    logic        rd_pend;
    logic        rd_last;
    logic        sums_ok;
    logic [31:0] checksum_q;
    logic [31:0] wr_sum;
    logic [31:0] rd_sum;

    imem_checksum u_wr_sum (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (session_start),
        .en     (accept),
        .din    (bus.s_data),
        .sum    (wr_sum)
    );

    imem_checksum u_rd_sum (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (session_start),
        .en     (rd_pend),
        .din    (bus.rdata_ext),
        .sum    (rd_sum)
    );

    // The last read word is still on rdata_ext when the decision is taken.
    assign rd_last     = rd_pend && !ren_q;
    assign sums_ok     = (wr_sum == checksum_q) && ((rd_sum + bus.rdata_ext) == checksum_q);
    assign bus.ren_ext = ren_q;
`else
    logic unused_inputs;
    assign unused_inputs = ^{checksum, bus.rdata_ext};
    assign bus.ren_ext   = 1'b0;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= RST_STATE;
            cnt        <= '0;
            len_q      <= '0;
            addr_q     <= RST_ADDR;
            wen_q      <= RST_FLAG;
            wdata_q    <= '0;
            cpu_enable <= RST_FLAG;
            busy       <= RST_FLAG;
            error      <= RST_FLAG;
`ifdef IMEM_LOADER_VERIFY_EN
            ren_q      <= RST_FLAG;
            rd_pend    <= RST_FLAG;
            checksum_q <= '0;
`endif
        end else begin
            // NOTE: strobes default low every cycle; the case below re-asserts them only when needed.
            wen_q <= 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
            ren_q   <= 1'b0;
            rd_pend <= ren_q;
`endif
            case (state)
                ST_IDLE, ST_RUN, ST_ERROR: begin
                    if (session_start) begin
                        len_q      <= len;
                        cnt        <= '0;
                        cpu_enable <= 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
                        checksum_q <= checksum;
`endif
                        if (len_legal) begin
                            state <= ST_LOAD;
                            busy  <= 1'b1;
                            error <= 1'b0;
                        end else begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        wen_q   <= 1'b1;
                        addr_q  <= word_to_byte(32'(cnt));
                        wdata_q <= bus.s_data;
                        cnt     <= cnt + 1'b1;
                    end else if (cnt == len_q) begin
`ifdef IMEM_LOADER_VERIFY_EN
                        state  <= ST_VERIFY;
                        ren_q  <= 1'b1;
                        addr_q <= RST_ADDR;
                        cnt    <= {{ADDR_W{1'b0}}, 1'b1};
`else
                        state      <= ST_RUN;
                        busy       <= 1'b0;
                        cpu_enable <= 1'b1;
`endif
                    end
                end
`ifdef IMEM_LOADER_VERIFY_EN
                ST_VERIFY: begin
                    if (cnt < len_q) begin
                        ren_q  <= 1'b1;
                        addr_q <= word_to_byte(32'(cnt));
                        cnt    <= cnt + 1'b1;
                    end
                    if (rd_last) begin
                        busy <= 1'b0;
                        if (sums_ok) begin
                            state      <= ST_RUN;
                            cpu_enable <= 1'b1;
                        end else begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table vectors, hand-written corner sequences and
// randomized sessions against a session-level reference model. Honours IMEM_LOADER_VERIFY_EN.
module tb_imem_loader;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int CAP    = 512;
`ifdef IMEM_LOADER_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            arst_n;
    logic            start;
    logic [ADDR_W:0] len;
    logic [31:0]     checksum;
    logic            cpu_enable;
    logic            busy;
    logic            error;

    imem_loader_if #(.DATA_W(DATA_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .start      (start),
        .len        (len),
        .checksum   (checksum),
        .bus        (bus),
        .cpu_enable (cpu_enable),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Instruction memory: synchronous write, one-cycle read latency.
    logic [31:0] mem [0:CAP-1];
    always @(posedge clk) begin
        if (bus.wen_ext) mem[bus.addr_ext[ADDR_W+1:2]] <= bus.wdata_ext;
        if (bus.ren_ext) bus.rdata_ext <= mem[bus.addr_ext[ADDR_W+1:2]];
    end

    // Bus monitor, sampled mid-cycle.
    int          cyc = 0;
    int          overlap = 0;
    logic        en_prev = 1'b0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    logic [31:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    int          en_q[$];

    always @(negedge clk) begin
        if (bus.wen_ext) begin
            wr_addr_q.push_back(bus.addr_ext);
            wr_data_q.push_back(bus.wdata_ext);
            wr_cyc_q.push_back(cyc);
        end
        if (bus.ren_ext) begin
            rd_addr_q.push_back(bus.addr_ext);
            rd_cyc_q.push_back(cyc);
        end
        if (bus.wen_ext && bus.ren_ext) overlap++;
        if (cpu_enable && !en_prev) en_q.push_back(cyc);
        en_prev = cpu_enable;
        cyc++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    logic [31:0] stim[$];

    task automatic fill_pattern(input int n, input logic [31:0] base, input logic [31:0] step);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(base + step * 32'(i));
    endtask

    // Session outcome from the rules alone: legality, sum, and whether verification gates RUN.
    function automatic void ref_model(input int n, input logic [31:0] cks, output int exp_wr,
                                      output bit exp_en, output bit exp_err, output logic [31:0] exp_sum);
        bit legal;
        legal   = (n >= 1) && (n <= CAP);
        exp_sum = 32'h0;
        for (int i = 0; i < n && i < stim.size(); i++) exp_sum = exp_sum + stim[i];
        exp_wr  = legal ? n : 0;
        exp_en  = legal && (!VFY || exp_sum == cks);
        exp_err = !exp_en;
    endfunction

    task automatic run_session(input int n, input logic [31:0] cks, input int gap, input bit mid_start,
                               input int exp_wr, input bit exp_en, input bit exp_err, input logic [31:0] exp_sum);
        int          wr_base = wr_addr_q.size();
        int          rd_base = rd_addr_q.size();
        int          en_base = en_q.size();
        int          i = 0;
        int          guard = 0;
        int          lim;
        int          first_acc = -1;
        int          last_acc = -1;
        int          nwr;
        int          nrd;
        int          nen;
        int          bad;
        int          ref_cyc;
        bit          mid_done = 1'b0;
        bit          acc;
        logic [31:0] obs_sum;

        start    = 1'b1;
        len      = n[ADDR_W:0];
        checksum = cks;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'(exp_wr > 0));
        check("error_after_start", 32'(error), 32'(exp_wr == 0));
        check("en_after_start", 32'(cpu_enable), 32'h0);

        lim = (exp_wr > 0) ? 4 * n + 20 : 6;
        while (i < stim.size() && guard < lim) begin
            guard++;
            start = 1'b0;
            if (mid_start && i == 2 && !mid_done) begin
                start    = 1'b1;
                len      = 10'd2;
                mid_done = 1'b1;
            end
            case (gap)
                0:       bus.s_valid = 1'b1;
                1:       bus.s_valid = (guard % 2) == 1;
                default: bus.s_valid = 1'($urandom_range(0, 1));
            endcase
            bus.s_data = stim[i];
            acc = bus.s_valid && bus.s_ready;
            if (acc) begin
                if (i == 0) first_acc = cyc;
                last_acc = cyc;
            end
            @(posedge clk); #1;
            if (acc) i++;
        end
        bus.s_valid = 1'b0;
        start       = 1'b0;
        check("accepted_words", i, exp_wr);
        check("s_ready_drop", 32'(bus.s_ready), 32'h0);

        for (int k = 0; k < 2 * n + 20 && busy; k++) begin
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        check("busy_done", 32'(busy), 32'h0);
        check("cpu_enable", 32'(cpu_enable), 32'(exp_en));
        check("error", 32'(error), 32'(exp_err));

        nwr = wr_addr_q.size() - wr_base;
        check("wr_count", nwr, exp_wr);
        bad     = 0;
        obs_sum = 32'h0;
        for (int k = 0; k < nwr; k++) begin
            if (wr_addr_q[wr_base + k] !== 32'(k * 4) ||
                (k < stim.size() && wr_data_q[wr_base + k] !== stim[k])) bad++;
            obs_sum = obs_sum + wr_data_q[wr_base + k];
        end
        check("wr_seq_errors", bad, 0);
        if (nwr > 0) begin
            check("wr_sum", obs_sum, exp_sum);
            check("last_wr_addr", wr_addr_q[$], 32'((nwr - 1) * 4));
            check("first_wr_latency", wr_cyc_q[wr_base], first_acc + 1);
            check("last_wr_latency", wr_cyc_q[$], last_acc + 1);
            if (gap == 0) check("back_to_back", wr_cyc_q[$] - wr_cyc_q[wr_base], nwr - 1);
        end

        nrd = rd_addr_q.size() - rd_base;
        check("rd_count", nrd, VFY ? exp_wr : 0);
        bad = 0;
        for (int k = 0; k < nrd; k++)
            if (rd_addr_q[rd_base + k] !== 32'(k * 4) || rd_cyc_q[rd_base + k] !== rd_cyc_q[rd_base] + k) bad++;
        check("rd_seq_errors", bad, 0);
        if (nrd > 0 && nwr > 0) check("rd_after_wr", rd_cyc_q[rd_base], wr_cyc_q[$] + 1);

        nen = en_q.size() - en_base;
        check("en_rises", nen, 32'(exp_en));
        if (nen > 0) begin
            ref_cyc = (nrd > 0) ? rd_cyc_q[$] + 2 : ((nwr > 0) ? wr_cyc_q[$] + 1 : -1);
            check("en_latency", en_q[$], ref_cyc);
        end
    endtask

    typedef struct {
        int          n;
        logic [31:0] cks;
        logic [31:0] base;
        logic [31:0] step;
        int          gap;
        int          exp_wr;
        bit          exp_en;
        bit          exp_err;
        logic [31:0] exp_sum;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int          n;
        int          exp_wr;
        bit          exp_en;
        bit          exp_err;
        logic [31:0] exp_sum;
        logic [31:0] cks;

        tbl[0] = '{4,   32'h0000_000A, 32'd1,         32'd1, 0, 4,   1'b1, 1'b0, 32'h0000_000A};
        tbl[1] = '{4,   32'h0000_000B, 32'd1,         32'd1, 0, 4,   !VFY, VFY,  32'h0000_000A};
        tbl[2] = '{0,   32'h0000_0000, 32'd1,         32'd1, 0, 0,   1'b0, 1'b1, 32'h0000_0000};
        tbl[3] = '{513, 32'h0000_0000, 32'd5,         32'd0, 0, 0,   1'b0, 1'b1, 32'h0000_0000};
        tbl[4] = '{512, 32'hFFFF_FE00, 32'hFFFF_FFFF, 32'd0, 1, 512, 1'b1, 1'b0, 32'hFFFF_FE00};
        tbl[5] = '{1,   32'h1234_5678, 32'h1234_5678, 32'd0, 0, 1,   1'b1, 1'b0, 32'h1234_5678};

        arst_n      = 1'b0;
        start       = 1'b0;
        len         = '0;
        checksum    = 32'h0;
        bus.s_valid = 1'b0;
        bus.s_data  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready", 32'(bus.s_ready), 32'h0);
        check("rst_wen", 32'(bus.wen_ext), 32'h0);
        check("rst_ren", 32'(bus.ren_ext), 32'h0);
        check("rst_addr", bus.addr_ext, 32'h0);
        check("rst_wdata", bus.wdata_ext, 32'h0);
        check("rst_cpu_enable", 32'(cpu_enable), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        @(negedge clk) arst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[t]) begin
            fill_pattern(tbl[t].n, tbl[t].base, tbl[t].step);
            run_session(tbl[t].n, tbl[t].cks, tbl[t].gap, 1'b0,
                        tbl[t].exp_wr, tbl[t].exp_en, tbl[t].exp_err, tbl[t].exp_sum);
        end

        // start while RUN: cpu_enable must drop and a new load begin.
        fill_pattern(3, 32'h100, 32'h10);
        ref_model(3, 32'h330, exp_wr, exp_en, exp_err, exp_sum);
        run_session(3, 32'h330, 0, 1'b0, exp_wr, exp_en, exp_err, exp_sum);
        check("en_held_in_run", 32'(cpu_enable), 32'h1);
        fill_pattern(3, 32'h7, 32'h1);
        ref_model(3, 32'h18, exp_wr, exp_en, exp_err, exp_sum);
        run_session(3, 32'h18, 0, 1'b0, exp_wr, exp_en, exp_err, exp_sum);

        // start during LOAD is ignored: still four writes.
        fill_pattern(4, 32'hA0, 32'h3);
        ref_model(4, 32'h292, exp_wr, exp_en, exp_err, exp_sum);
        run_session(4, 32'h292, 0, 1'b1, exp_wr, exp_en, exp_err, exp_sum);

        // Asynchronous reset after two of four words, then a clean reload from address 0.
        fill_pattern(4, 32'd1, 32'd1);
        start    = 1'b1;
        len      = 10'd4;
        checksum = 32'hA;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = stim[k];
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        check("pre_rst_wen", 32'(bus.wen_ext), 32'h1);
        check("pre_rst_addr", bus.addr_ext, 32'h4);
        #1 arst_n = 1'b0;
        #1;
        check("arst_s_ready", 32'(bus.s_ready), 32'h0);
        check("arst_wen", 32'(bus.wen_ext), 32'h0);
        check("arst_addr", bus.addr_ext, 32'h0);
        check("arst_wdata", bus.wdata_ext, 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_cpu_enable", 32'(cpu_enable), 32'h0);
        check("arst_error", 32'(error), 32'h0);
        @(negedge clk) arst_n = 1'b1;
        @(posedge clk); #1;
        run_session(4, 32'hA, 0, 1'b0, 4, 1'b1, 1'b0, 32'hA);

        // Randomized sessions checked against the reference model.
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(0, 24);
            stim.delete();
            for (int k = 0; k < n; k++) stim.push_back($urandom);
            cks = 32'h0;
            foreach (stim[k]) cks = cks + stim[k];
            if ($urandom_range(0, 2) == 0) cks = cks + 32'h1;
            ref_model(n, cks, exp_wr, exp_en, exp_err, exp_sum);
            run_session(n, cks, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                        exp_wr, exp_en, exp_err, exp_sum);
        end

        check("wen_ren_overlap", overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction loader sitting directly upstream of the `cpu` top. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into instruction memory through the CPU's external port (`addr_ext`/`wen_ext`/`wdata_ext`). Optionally, it reads every word back and checks a checksum. It then raises the CPU `enable` so execution starts from address 0 with a fully loaded program.

## Interface
Parameters:
- `ADDR_W`, 9, instruction-memory word-address width; capacity is `2**ADDR_W` words.
- `DATA_W`, 32, instruction word width.

Ports:
- `clk`  in  1  main clock.
- `arst_n`  in  1  reset; one clock, asynchronous, active-low.
- `start`  in  1  single-cycle pulse; begins a load session.
- `len`  in  ADDR_W+1  number of words to load; sampled on `start`.
- `checksum`  in  32  expected sum of all words, modulo 2^32; sampled on `start`.
- `s_valid`  in  1  stream word valid.
- `s_ready`  out  1  loader can accept a word.
- `s_data`  in  DATA_W  stream word.
- `addr_ext`  out  32  byte address to instruction memory.
- `wen_ext`  out  1  instruction-memory write enable.
- `ren_ext`  out  1  instruction-memory read enable.
- `wdata_ext`  out  DATA_W  instruction-memory write data.
- `rdata_ext`  in  DATA_W  instruction-memory read data; valid the cycle after `ren_ext`.
- `cpu_enable`  out  1  drives the CPU `enable` input.
- `busy`  out  1  a session is in progress (LOAD or VERIFY).
- `error`  out  1  the last session failed.

## Operation
- States: IDLE, LOAD, VERIFY, RUN, ERROR.
- IDLE → LOAD on `start` when 1 ≤ `len` ≤ 2**ADDR_W.
  - `start` with `len`=0 or `len`>2**ADDR_W → ERROR.
- LOAD:
  - `s_ready`=1 while the word counter is below `len`.
  - Each accepted word (`s_valid`&&`s_ready`) is written at byte address `idx*4`; `idx` counts from 0.
  - The running sum is `sum += s_data` (32-bit, wraps).
  - After the last write: → VERIFY if `IMEM_LOADER_VERIFY_EN`, otherwise → RUN.
- VERIFY:
  - Issues `ren_ext` for `idx` = 0..`len`-1, one per cycle; `addr_ext`=`idx*4`.
  - A second sum is accumulated over `rdata_ext`.
  - When the last read data returns: both sums equal `checksum` → RUN; otherwise → ERROR.
- RUN: `cpu_enable`=1; stays until reset or a new `start`.
- ERROR: `error`=1, `cpu_enable`=0; stays until reset or a new `start`.
- `start` in RUN or ERROR:
  - Clears `error` and deasserts `cpu_enable`.
  - Restarts the session (same legality check as IDLE).
- `start` during LOAD or VERIFY is ignored.
- `wen_ext` and `ren_ext` are never asserted in the same cycle.
- Reset mid-session: all state is cleared and the partially loaded memory is abandoned; the loader returns to IDLE.

## Timing
- Reset values:
  - `s_ready`, `wen_ext`, `ren_ext`, `cpu_enable`, `busy`, `error` = 0.
  - `addr_ext`, `wdata_ext` = 0.
  - State is IDLE.
- All outputs are registered except `s_ready`, which is decoded from the state and counter.
- Write latency: a word accepted in cycle N appears as `wen_ext`/`addr_ext`/`wdata_ext` in cycle N+1.
- Throughput: 1 word/cycle.
- Back-to-back `s_valid` gives `len` consecutive write cycles.
- Stream bubbles insert idle cycles with `wen_ext`=0.
- `busy` rises the cycle after `start` and falls the cycle the state leaves VERIFY, or LOAD when verification is compiled out.
- `cpu_enable` rises 1 cycle after the last write (no verify) or 1 cycle after the last read data (verify).
- Verify pass: `len`+1 cycles (reads pipelined, 1-cycle read latency).

## Configuration
- `IMEM_LOADER_VERIFY_EN` defined:
  - The VERIFY state exists.
  - The `checksum` comparison gates the transition to RUN.
- Not defined:
  - VERIFY and the sum logic are removed; `ren_ext` is tied to 0.
  - `checksum` is ignored.
  - `error` is raised only for an illegal `len`.

## Structure
- Package `imem_loader_pkg`:
  - State enum.
  - `WORD_BYTES`=4 (byte-address shift).
  - Reset constants.
- Sub-module `imem_checksum`:
  - Clear and accumulate-enable inputs; 32-bit wrapping sum.
  - Instanced once for the write stream.
  - Instanced once more for read-back, under `IMEM_LOADER_VERIFY_EN`.

## Test plan
- Reset, then `start` with `len`=4, `checksum`=0x0000_000A, words 1,2,3,4 back-to-back:
  - Writes at `addr_ext` 0, 4, 8, 12 on consecutive cycles.
  - With verify: 4 reads, then `cpu_enable`=1 and `error`=0.
- Same load with `checksum`=0x0000_000B:
  - With verify: `error`=1, `cpu_enable` stays 0.
  - Without verify: `cpu_enable`=1.
- `len`=0 → `error`=1 next cycle, no `wen_ext`.
- `len`=513 with `ADDR_W`=9 → `error`=1, no `wen_ext`.
- `len`=512 with 0xFFFF_FFFF words and `s_valid` toggling every other cycle:
  - 512 writes, last at `addr_ext`=0x7FC.
  - Sum wraps to 0xFFFF_FE00.
  - `s_ready` drops after the last word.
- `arst_n` pulsed low after 2 of 4 words:
  - All outputs return to 0 asynchronously.
  - A new `start` reloads from `addr_ext`=0.
- `start` in RUN → `cpu_enable` falls next cycle and a new load begins.
- `start` during LOAD → ignored; word count unaffected.
